beta_alu_pipe: RTL and testbench
================================

# beta_alu_pipe

Parametrised, registered successor to the combinational Beta ALU, with a valid/ready handshake on both input and output. It implements the full Beta ALU function set, including MUL, on an iterative shift-add datapath. Single-cycle ops return in 1 cycle; MUL occupies the block for WIDTH cycles. It sits between the register-read stage and writeback. Stall signalling comes from the handshake, not from external control.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4, power of two)
- MUL_EN, 1, 1 = MUL implemented; 0 = opcode 0010 executes as ADD, no multiplier logic
- SHW, $clog2(WIDTH), shift-amount bits taken from in_b (derived, not overridden)

- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts the operation this cycle
- alu_fn  in  4  opcode, sampled on acceptance
- in_a  in  WIDTH  operand A, sampled on acceptance
- in_b  in  WIDTH  operand B, sampled on acceptance
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes the result this cycle
- result  out  WIDTH  registered result
- busy  out  1  multiply in progress

## Operation
- Accept when in_valid && in_ready. Consume when out_valid && out_ready.
- Opcodes. All arithmetic is modulo 2^WIDTH.
  - 0000 ADD: A+B
  - 0001 SUB: A−B
  - 0010 MUL: low WIDTH bits of A·B
  - 0100 CMPEQ: A==B
  - 0101 CMPLT: signed A<B
  - 0110 CMPLE: signed A≤B
  - 1000 AND: A&B
  - 1001 OR: bitwise A|B
  - 1010 XOR: A^B
  - 1011 XNOR: bitwise ~(A^B)
  - 1100 SHL: A<<B[SHW-1:0]
  - 1101 SHR: logical A>>B[SHW-1:0]
  - 1110 SRA: arithmetic, sign-filled
  - All other codes: ADD
- Compare results are zero-extended to WIDTH (0 or 1).
- Only B[SHW-1:0] is used as the shift amount. Upper bits of B are ignored.
- State machine: IDLE, MUL.
  - IDLE→MUL: on accepting MUL with MUL_EN=1. The block loads the multiplicand (A), the multiplier (B), a zeroed accumulator and a count of WIDTH.
  - MUL: each cycle, if the multiplier LSB is set, add the multiplicand to the accumulator. Then shift the multiplicand left, shift the multiplier right, and decrement the count.
  - MUL→IDLE: on the final iteration, write the accumulator result into `result` and set out_valid.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready). This allows accept and drain in the same cycle, giving back-to-back throughput of 1 op/cycle.
- busy = (state==MUL).
- `result` and out_valid change only on acceptance of a single-cycle op, on MUL completion, or on consumption. When out_valid=0, `result` holds its last value.

## Timing
- Reset values:
  - out_valid=0, result=0, busy=0, state=IDLE
  - in_ready=0 while rst=1; in_ready=1 in the first cycle after rst deasserts
- Single-cycle op accepted at edge k: result and out_valid=1 are visible after edge k. Latency is 1.
- MUL accepted at edge k: iterations occur on edges k+1…k+WIDTH. out_valid=1 is visible after edge k+WIDTH. in_ready=0 from after edge k until after edge k+WIDTH.
- Backpressure: while out_valid=1 and out_ready=0, result and out_valid hold stable and in_ready=0. No result is ever overwritten or dropped.
- Simultaneous consume and accept (single-cycle op): the new result replaces the old one and out_valid stays 1.
- Consume with no accept: out_valid→0 on that edge.
- A MUL may be accepted while an older result is being consumed in the same cycle. out_valid→0, then returns to 1 at completion.
- rst mid-MUL: the operation is aborted and no result is produced. The next cycle shows state=IDLE and out_valid=0.
- rst overrides any simultaneous accept or consume.
- Inputs are sampled only on acceptance. Changes to in_a/in_b/alu_fn during MUL have no effect.

## Test plan
- Reset, then ADD 0xFFFFFFFF+1 and SUB 0−1 back-to-back with out_ready=1 → results 0x00000000 then 0xFFFFFFFF on consecutive cycles, in_ready held at 1.
- CMPLT A=0xFFFFFFFF, B=1 → 1; CMPLE A=B=5 → 1; CMPEQ 3,4 → 0.
- SRA 0x80000000 by B=0x24 (amount 4) → 0xF8000000; SHR same → 0x08000000; SHL 1 by 31 → 0x80000000.
- MUL 7×6 with WIDTH=32 → result 42, out_valid rises exactly 32 cycles after acceptance, busy high for 32 cycles, in_ready low throughout. MUL 0xFFFFFFFF×0xFFFFFFFF → 1.
- out_ready=0 for 5 cycles after an ADD, with in_valid held high → result stable, in_ready=0, and the second op is accepted only in the cycle out_ready=1.
- Assert rst at iteration 10 of a MUL → out_valid=0, busy=0 next cycle. An ADD 2+3 issued after reset returns 5. Repeat with MUL_EN=0: MUL 2,3 → 5.

Source files
------------

// File: rtl/beta_alu_pipe.sv
// Registered Beta ALU with valid/ready handshakes on both sides.
// Single-cycle ops return in one cycle; MUL iterates shift-add for WIDTH cycles.
module beta_alu_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_fn,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH) + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   sh;
    logic             is_mul;
    logic             accept;
    logic             mul_last;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mlr_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_nxt;
    logic [CW-1:0]    cnt_q;

    assign is_mul   = MUL_EN && (alu_fn == 4'b0010);
    assign accept   = in_valid && in_ready;
    assign mul_last = (cnt_q == CW'(1));
    assign acc_nxt  = acc_q + (mlr_q[0] ? mcand_q : '0);

    // Single-cycle function unit; unlisted opcodes (and MUL when disabled) add.
    always_comb begin
        sh      = in_b[SHW-1:0];
        alu_res = in_a + in_b;
        case (alu_fn)
            4'b0001: alu_res = in_a - in_b;
            4'b0100: alu_res = WIDTH'(in_a == in_b);
            4'b0101: alu_res = WIDTH'($signed(in_a) < $signed(in_b));
            4'b0110: alu_res = WIDTH'($signed(in_a) <= $signed(in_b));
            4'b1000: alu_res = in_a & in_b;
            4'b1001: alu_res = in_a | in_b;
            4'b1010: alu_res = in_a ^ in_b;
            4'b1011: alu_res = ~(in_a ^ in_b);
            4'b1100: alu_res = in_a << sh;
            4'b1101: alu_res = in_a >> sh;
            4'b1110: alu_res = WIDTH'($signed(in_a) >>> sh);
            default: alu_res = in_a + in_b;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && is_mul) state_d = S_MUL;
            S_MUL:  if (mul_last)         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; in_ready lets a drain and a new accept share one cycle.
    always_comb begin
        busy     = (state_q == S_MUL);
        in_ready = !rst && (state_q == S_IDLE) && (!out_valid || out_ready);
    end

    // Result register and multiplier datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            mcand_q   <= '0;
            mlr_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else if (accept) begin
            if (is_mul) begin
                mcand_q   <= in_a;
                mlr_q     <= in_b;
                acc_q     <= '0;
                cnt_q     <= CW'(WIDTH);
                out_valid <= 1'b0;
            end else begin
                result    <= alu_res;
                out_valid <= 1'b1;
            end
        end else if (busy) begin
            acc_q   <= acc_nxt;
            mcand_q <= mcand_q << 1;
            mlr_q   <= mlr_q >> 1;
            cnt_q   <= cnt_q - CW'(1);
            if (mul_last) begin
                result    <= acc_nxt;
                out_valid <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_beta_alu_pipe.sv
// Directed bench for beta_alu_pipe: vector table plus handshake/MUL/reset sequences.
module tb_beta_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]  alu_fn;
    logic [31:0] in_a, in_b, result;

    logic        b_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [3:0]  b_fn;
    logic [31:0] b_a, b_b, b_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beta_alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_fn(alu_fn), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    beta_alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_in_ready),
        .alu_fn(b_fn), .in_a(b_a), .in_b(b_b), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .result(b_result), .busy(b_busy)
    );

    typedef struct {
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid after a MUL accept, counting busy cycles and in_ready leaks.
    task automatic wait_mul(input string name, input logic [31:0] exp);
        int cycles = 0;
        int busy_cnt = 0;
        int ready_seen = 0;
        while (!out_valid && cycles < 100) begin
            if (busy) busy_cnt++;
            if (in_ready) ready_seen++;
            in_a = 32'd99;
            in_b = 32'd77;
            step();
            cycles++;
        end
        check({name, "_latency"}, 32'(cycles), 32'd32);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd32);
        check({name, "_ready_low"}, 32'(ready_seen), 32'd0);
        check({name, "_result"}, result, exp);
        check({name, "_busy_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int hold_bad;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; alu_fn = 4'h0; in_a = '0; in_b = '0;
        b_valid = 1'b0; b_out_ready = 1'b0; b_fn = 4'h0; b_a = '0; b_b = '0;

        vecs.push_back('{4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
        vecs.push_back('{4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
        vecs.push_back('{4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001});
        vecs.push_back('{4'b0110, 32'h00000005, 32'h00000005, 32'h00000001});
        vecs.push_back('{4'b0100, 32'h00000003, 32'h00000004, 32'h00000000});
        vecs.push_back('{4'b1110, 32'h80000000, 32'h00000024, 32'hF8000000});
        vecs.push_back('{4'b1101, 32'h80000000, 32'h00000024, 32'h08000000});
        vecs.push_back('{4'b1100, 32'h00000001, 32'h0000001F, 32'h80000000});
        vecs.push_back('{4'b1000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000});
        vecs.push_back('{4'b1001, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0});
        vecs.push_back('{4'b1010, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0});
        vecs.push_back('{4'b1011, 32'h0000F0F0, 32'h0000FF00, 32'hFFFFF00F});
        vecs.push_back('{4'b0101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000});
        vecs.push_back('{4'b0110, 32'h00000006, 32'h00000005, 32'h00000000});
        vecs.push_back('{4'b0011, 32'h00000007, 32'h00000008, 32'h0000000F});
        vecs.push_back('{4'b1111, 32'h00000001, 32'h00000001, 32'h00000002});

        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle ops with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = 1'b1;
            alu_fn = vecs[i].fn;
            in_a = vecs[i].a;
            in_b = vecs[i].b;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            step();
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_result", i), result, vecs[i].exp);
        end

        // MUL accepted while the previous result drains
        alu_fn = 4'b0010; in_a = 32'd7; in_b = 32'd6;
        step();
        in_valid = 1'b0;
        check("mul_accept_clears_valid", 32'(out_valid), 32'd0);
        check("mul_busy_start", 32'(busy), 32'd1);
        wait_mul("mul7x6", 32'd42);

        in_valid = 1'b1; alu_fn = 4'b0010; in_a = 32'hFFFFFFFF; in_b = 32'hFFFFFFFF;
        step();
        in_valid = 1'b0;
        wait_mul("mul_ff", 32'd1);

        // Backpressure: result held, next op waits for out_ready
        out_ready = 1'b0;
        in_valid = 1'b1; alu_fn = 4'b0000; in_a = 32'd10; in_b = 32'd20;
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'd1) hold_bad++;
            step();
        end
        check("bp_hold", 32'(hold_bad), 32'd0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_result", result, 32'd30);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        check("drain_no_accept", 32'(out_valid), 32'd0);

        // Reset on iteration 10 of a MUL aborts it
        in_valid = 1'b1; alu_fn = 4'b0010; in_a = 32'd5; in_b = 32'd5;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        check("mid_mul_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(in_ready), 32'd1);
        in_valid = 1'b1; alu_fn = 4'b0000; in_a = 32'd2; in_b = 32'd3;
        step();
        in_valid = 1'b0;
        check("add_after_abort", result, 32'd5);
        check("add_after_abort_valid", 32'(out_valid), 32'd1);

        // Without the multiplier, opcode 0010 adds
        b_valid = 1'b1; b_out_ready = 1'b1; b_fn = 4'b0010; b_a = 32'd2; b_b = 32'd3;
        #1;
        check("nomul_in_ready", 32'(b_in_ready), 32'd1);
        step();
        b_valid = 1'b0;
        check("nomul_result", b_result, 32'd5);
        check("nomul_out_valid", 32'(b_out_valid), 32'd1);
        check("nomul_busy", 32'(b_busy), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
